// File: rtl/regfile_sb_multiport.sv
// Multi-port register file with a per-register pending scoreboard and a post-reset clear sweep.
// Define RF_BYPASS_EN to forward same-cycle writeback data and readiness to the read ports.
//
// state  | meaning
// S_INIT | clearing storage one entry per cycle; reads return 0/not-ready; writes and allocs ignored
// S_RUN  | normal operation
module regfile_sb_multiport #(
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR-1:0]        alloc_en,
  input  logic [NUM_WR*ADDR_W-1:0] alloc_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  output logic                     init_busy
);

  localparam int NUM_REGS = 2**ADDR_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic [DATA_W-1:0]   r_mem [NUM_REGS];

  logic [ADDR_W-1:0]   w_wa [NUM_WR];
  logic [DATA_W-1:0]   w_wd [NUM_WR];
  logic [ADDR_W-1:0]   w_aa [NUM_WR];
  logic [ADDR_W-1:0]   w_ra [NUM_RD];

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign w_wa[k] = wr_addr[k*ADDR_W +: ADDR_W];
    assign w_wd[k] = wr_data[k*DATA_W +: DATA_W];
    assign w_aa[k] = alloc_addr[k*ADDR_W +: ADDR_W];
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    assign w_ra[j] = rd_addr[j*ADDR_W +: ADDR_W];
  end

  assign init_busy = (r_state == S_INIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= (r_state == S_INIT) ? r_ptr + ADDR_W'(1) : '0;
      r_pend  <= w_pend_nxt;
    end
  end

  // Allocation is applied after writeback so a same-cycle alloc leaves the entry pending.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    case (r_state)
      S_INIT: begin
        if (r_ptr == ADDR_W'(NUM_REGS-1)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_en[k] && (w_wa[k] != '0)) w_pend_nxt[w_wa[k]] = 1'b0;
        end
        for (int k = 0; k < NUM_WR; k++) begin
          if (alloc_en[k] && (w_aa[k] != '0)) w_pend_nxt[w_aa[k]] = 1'b1;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // No reset term on the array so it can map onto RAM; the sweep provides the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (r_state == S_INIT) begin
        r_mem[r_ptr] <= '0;
      end else begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_en[k] && (w_wa[k] != '0)) r_mem[w_wa[k]] <= w_wd[k];
        end
      end
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (r_state == S_RUN) begin
        if (w_ra[j] == '0) begin
          rd_ready[j] = 1'b1;
        end else begin
          rd_data[j*DATA_W +: DATA_W] = r_mem[w_ra[j]];
          rd_ready[j]                 = ~r_pend[w_ra[j]];
`ifdef RF_BYPASS_EN
          for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && (w_wa[k] == w_ra[j])) begin
              rd_data[j*DATA_W +: DATA_W] = w_wd[k];
              rd_ready[j]                 = 1'b1;
            end
          end
`endif
        end
      end
    end
  end

endmodule
